block_a_rx: RTL and testbench

Receive-side collector for the sample stream that block_a emits on data_out_t_2 and qualifies with data_en. It packs PACK consecutive qualified samples into one word and buffers the words in a small first-word-fall-through FIFO. Words leave on a valid/ready port. A clk_en throttle is driven back to the producer so the producer can pause before the FIFO overflows.

---
 rtl/block_a_rx.sv | 144 ++++++++++++++
 tb/tb_block_a_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/block_a_rx.sv
`default_nettype none
// ============================================================================
// Module      : block_a_rx
// Description : Receive-side collector for the block_a sample stream. Packs
//               PACK qualified samples per word, buffers words in a
//               first-word-fall-through FIFO and throttles the producer.
// Revision    : 1.0 - initial release
// ============================================================================
module block_a_rx #(
    parameter int DATA2 = 3,
    parameter int PACK  = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         data_en,
    input  logic [DATA2:0]               data_in,
    input  logic                         flush,
    output logic [PACK*(DATA2+1)-1:0]    word_out,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic                         clk_en,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   fill
);

    localparam int c_SW     = DATA2 + 1;
    localparam int c_WW     = PACK * c_SW;
    localparam int c_IDX_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_FILL_W = $clog2(DEPTH + 1);

    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(PACK - 1);
    localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(DEPTH);
    localparam logic [c_FILL_W-1:0] c_FILL_HIGH = c_FILL_W'(DEPTH - 1);

    // Packer state
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_WW-1:0]     r_pack;
    logic [c_WW-1:0]     w_pack_next;
    logic                w_complete;
    logic                w_push;

    // FIFO state
    logic [c_WW-1:0]     r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_FILL_W-1:0] r_fill;
    logic [c_WW-1:0]     r_head;
    logic                r_overflow;

    logic                w_pop;
    logic                w_full;
    logic                w_wr;
    logic                w_drop;
    logic [c_PTR_W-1:0]  w_rd_next;
    logic [c_FILL_W-1:0] w_fill_next;

    // Merge this cycle's sample into its slot and decide whether a word leaves the packer
    always_comb begin
        w_pack_next = r_pack;
        for (int s = 0; s < PACK; s++) begin
            if (data_en && (r_idx == c_IDX_W'(s))) begin
                w_pack_next[s*c_SW +: c_SW] = data_in;
            end
        end
        w_complete = data_en && (r_idx == c_IDX_LAST);
        // A flush only produces a word if there is at least one sample in it
        w_push     = w_complete || (flush && (data_en || (r_idx != '0)));
    end

    // FIFO write/read qualification; a pop frees the slot a same-cycle push needs
    always_comb begin
        w_pop       = (r_fill != '0) && word_ready;
        w_full      = (r_fill == c_FILL_FULL);
        w_wr        = w_push && (!w_full || w_pop);
        w_drop      = w_push && w_full && !w_pop;
        w_rd_next   = w_pop ? (r_rd_ptr + c_PTR_W'(1)) : r_rd_ptr;
        w_fill_next = r_fill;
        case ({w_wr, w_pop})
            2'b10:   w_fill_next = r_fill + c_FILL_W'(1);
            2'b01:   w_fill_next = r_fill - c_FILL_W'(1);
            default: w_fill_next = r_fill;
        endcase
    end

    // Packer registers: slot index and partially assembled word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx  <= '0;
            r_pack <= '0;
        end else if (w_push) begin
            // Word leaves even if the FIFO drops it; packer always restarts clean
            r_idx  <= '0;
            r_pack <= '0;
        end else if (data_en) begin
            r_idx  <= r_idx + c_IDX_W'(1);
            r_pack <= w_pack_next;
        end
    end

    // FIFO storage; contents are only observed through the registered head
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_pack_next;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_fill   <= w_fill_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Registered head word; bypasses the array when the new head is being written now
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
        end else if (w_fill_next != '0) begin
            r_head <= (w_wr && (r_wr_ptr == w_rd_next)) ? w_pack_next : r_mem[w_rd_next];
        end
    end

    assign word_out   = r_head;
    assign word_valid = (r_fill != '0);
    assign clk_en     = (r_fill < c_FILL_HIGH);
    assign overflow   = r_overflow;
    assign fill       = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_block_a_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_a_rx
// Description : Scoreboard bench for block_a_rx with a queue-based reference
//               model, directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_a_rx;

    localparam int DATA2 = 3;
    localparam int PACK  = 4;
    localparam int DEPTH = 4;
    localparam int SW    = DATA2 + 1;
    localparam int WW    = PACK * SW;
    localparam int FW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_en = 1'b0;
    logic [SW-1:0] data_in = '0;
    logic          flush = 1'b0;
    logic          word_ready = 1'b0;
    logic [WW-1:0] word_out;
    logic          word_valid;
    logic          clk_en;
    logic          overflow;
    logic [FW-1:0] fill;

    int total = 0;
    int bad   = 0;

    block_a_rx #(.DATA2(DATA2), .PACK(PACK), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_en    (data_en),
        .data_in    (data_in),
        .flush      (flush),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .clk_en     (clk_en),
        .overflow   (overflow),
        .fill       (fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: list of samples, list of words ------
    logic [SW-1:0] m_samp[$];
    logic [WW-1:0] exp_q[$];
    int            m_fill = 0;
    bit            m_ovf  = 1'b0;
    bit            m_pop;
    bit            m_push;
    logic [WW-1:0] m_word;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_samp.delete();
            exp_q.delete();
            m_fill = 0;
            m_ovf  = 1'b0;
        end else begin
            m_pop = (m_fill > 0) && word_ready;
            if (data_en) m_samp.push_back(data_in);
            m_push = (m_samp.size() == PACK) || (flush && (m_samp.size() > 0));
            if (m_push) begin
                m_word = '0;
                foreach (m_samp[i]) m_word = m_word | (WW'(m_samp[i]) << (i * SW));
                m_samp.delete();
                if (m_fill < DEPTH || m_pop) begin
                    exp_q.push_back(m_word);
                    m_fill = m_fill + 1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (m_pop) m_fill = m_fill - 1;
        end
    end

    // ---------------- monitor: status every cycle, words on each handshake --
    always @(negedge clk) begin
        chk("word_valid", 32'(word_valid), 32'(m_fill > 0));
        chk("fill", 32'(fill), 32'(m_fill));
        chk("clk_en", 32'(clk_en), 32'(m_fill < DEPTH - 1));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (!rst) chk("reset_word_out", 32'(word_out), 32'h0);
        if (rst && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(word_out), 32'hDEAD_BEEF);
            end else begin
                chk("word_out", 32'(word_out), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic cyc(input logic en, input logic [SW-1:0] d, input logic fl, input logic rdy);
        data_en    = en;
        data_in    = d;
        flush      = fl;
        word_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WW-1:0] w, input logic rdy);
        for (int i = 0; i < PACK; i++) cyc(1'b1, w[i*SW +: SW], 1'b0, rdy);
    endtask

    task automatic pulse_rst();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 4 * DEPTH && word_valid; k++) cyc(1'b0, SW'($urandom), 1'b0, 1'b1);
        chk("drain_valid", 32'(word_valid), 32'h0);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        #1;
        // Reset with random inputs
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(1'($urandom), SW'($urandom), 1'($urandom), 1'($urandom));
            chk("rst_valid", 32'(word_valid), 32'h0);
            chk("rst_fill", 32'(fill), 32'h0);
            chk("rst_ovf", 32'(overflow), 32'h0);
            chk("rst_clk_en", 32'(clk_en), 32'h1);
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) cyc(1'b0, SW'($urandom), 1'($urandom), 1'($urandom));
        chk("post_rst_valid", 32'(word_valid), 32'h0);
        chk("post_rst_fill", 32'(fill), 32'h0);

        // Basic pack, back to back
        send_word(16'h4321, 1'b1);
        chk("pack_valid", 32'(word_valid), 32'h1);
        chk("pack_word", 32'(word_out), 32'h4321);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("pack_one_cycle", 32'(word_valid), 32'h0);

        // Basic pack with gaps carrying junk data
        cyc(1'b1, 4'h1, 1'b0, 1'b1);
        cyc(1'b0, SW'($urandom), 1'b0, 1'b1);
        cyc(1'b0, SW'($urandom), 1'b0, 1'b1);
        cyc(1'b1, 4'h2, 1'b0, 1'b1);
        cyc(1'b0, SW'($urandom), 1'b0, 1'b1);
        cyc(1'b1, 4'h3, 1'b0, 1'b1);
        chk("gap_not_early", 32'(word_valid), 32'h0);
        cyc(1'b1, 4'h4, 1'b0, 1'b1);
        chk("gap_word", 32'(word_out), 32'h4321);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);

        // Backpressure and overflow
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        chk("bp_clk_en_at_2", 32'(clk_en), 32'h1);
        send_word(16'h3333, 1'b0);
        chk("bp_clk_en_at_3", 32'(clk_en), 32'h0);
        send_word(16'h4444, 1'b0);
        chk("bp_fill_4", 32'(fill), 32'h4);
        chk("bp_no_ovf_yet", 32'(overflow), 32'h0);
        send_word(16'h5555, 1'b0);
        chk("bp_ovf", 32'(overflow), 32'h1);
        chk("bp_fill_sat", 32'(fill), 32'h4);
        chk("bp_head", 32'(word_out), 32'h1111);
        drain();
        chk("bp_ovf_sticky", 32'(overflow), 32'h1);

        // Full with simultaneous push and pop
        pulse_rst();
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        send_word(16'h1234, 1'b0);
        send_word(16'h5678, 1'b0);
        send_word(16'h9ABC, 1'b0);
        send_word(16'hDEF0, 1'b0);
        chk("full_fill", 32'(fill), 32'h4);
        cyc(1'b1, 4'hD, 1'b0, 1'b0);
        cyc(1'b1, 4'hE, 1'b0, 1'b0);
        cyc(1'b1, 4'hF, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 1'b0, 1'b1);
        chk("full_pp_fill", 32'(fill), 32'h4);
        chk("full_pp_ovf", 32'(overflow), 32'h0);
        chk("full_pp_head", 32'(word_out), 32'h5678);
        drain();

        // Flush cases
        cyc(1'b1, 4'hA, 1'b0, 1'b1);
        cyc(1'b1, 4'hB, 1'b0, 1'b1);
        cyc(1'b0, SW'($urandom), 1'b1, 1'b1);
        chk("flush_valid", 32'(word_valid), 32'h1);
        chk("flush_word", 32'(word_out), 32'h00BA);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        cyc(1'b0, SW'($urandom), 1'b1, 1'b1);
        chk("flush_idle_valid", 32'(word_valid), 32'h0);
        chk("flush_idle_fill", 32'(fill), 32'h0);
        cyc(1'b1, 4'h1, 1'b0, 1'b1);
        cyc(1'b1, 4'h2, 1'b0, 1'b1);
        cyc(1'b1, 4'h3, 1'b0, 1'b1);
        cyc(1'b1, 4'h4, 1'b1, 1'b1);
        chk("flush_full_word", 32'(word_out), 32'h4321);
        chk("flush_full_fill", 32'(fill), 32'h1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("flush_full_single", 32'(word_valid), 32'h0);

        // Reset mid-operation
        send_word(16'h1357, 1'b0);
        send_word(16'h2468, 1'b0);
        cyc(1'b1, 4'h5, 1'b0, 1'b0);
        cyc(1'b1, 4'h6, 1'b0, 1'b0);
        pulse_rst();
        chk("midrst_fill", 32'(fill), 32'h0);
        chk("midrst_valid", 32'(word_valid), 32'h0);
        cyc(1'b1, 4'h7, 1'b0, 1'b1);
        cyc(1'b1, 4'h8, 1'b0, 1'b1);
        cyc(1'b1, 4'h9, 1'b0, 1'b1);
        cyc(1'b1, 4'hA, 1'b0, 1'b1);
        chk("midrst_fresh_word", 32'(word_out), 32'hA987);
        drain();

        // Randomized traffic; the producer mostly honours clk_en
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 599) == 0) pulse_rst();
            cyc(($urandom_range(0, 2) != 0) && (clk_en || ($urandom_range(0, 7) == 0)),
                SW'($urandom),
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 2) != 0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
